acl_readings_ascii_formatter: RTL and testbench



---
 rtl/acl_ascii_pkg.sv | 36 +++
 rtl/bin_to_bcd_serial.sv | 62 ++++++
 rtl/acl_readings_ascii_formatter.sv | 206 ++++++++++++++++++++
 tb/tb_acl_readings_ascii_formatter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/acl_ascii_pkg.sv
// Shared types, ASCII constants and sizing helpers for the sensor text formatters.
package acl_ascii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_POINT = 8'h2E;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_UNDER = 8'h5F;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Uppercase hex character for one nibble.
  function automatic logic [7:0] ascii_of_hdigit(input logic [3:0] d);
    if (d < 4'd10) return ASCII_ZERO + {4'h0, d};
    else return 8'h37 + {4'h0, d};
  endfunction

  // Characters per field: label, sign, digits, point slot, trailing space.
  function automatic int unsigned field_width(input int unsigned digits);
    return digits + 32'd4;
  endfunction

  // BCD bits needed to hold any unsigned value of the given bit width.
  function automatic int unsigned bcd_width(input int unsigned width);
    return 32'd4 * ((width * 32'd3) / 32'd10 + 32'd1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one bit per cycle.
module bin_to_bcd_serial
  import acl_ascii_pkg::*;
#(
  parameter int unsigned PARM_WIDTH = 16
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [PARM_WIDTH-1:0]               i_bin,
  output logic [bcd_width(PARM_WIDTH)-1:0]    o_bcd,
  output logic                                o_last,
  output logic                                o_done
);

  localparam int unsigned BCD_W = bcd_width(PARM_WIDTH);
  localparam int unsigned NIB   = BCD_W / 4;
  localparam int unsigned CNT_W = $clog2(PARM_WIDTH + 1);

  logic [PARM_WIDTH-1:0] sh_q;
  logic [BCD_W-1:0]      bcd_q;
  logic [BCD_W-1:0]      adj_c;
  logic [CNT_W-1:0]      cnt_q;

  assign o_bcd = bcd_q;

  // Add 3 to every nibble that would reach 10 or more after doubling.
  always_comb begin
    adj_c = bcd_q;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) adj_c[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one magnitude bit in per cycle; o_last flags the
  // final step, o_done marks the first cycle with the finished result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      o_last <= 1'b0;
      o_done <= 1'b0;
    end else if (i_start) begin
      sh_q   <= i_bin;
      bcd_q  <= '0;
      cnt_q  <= CNT_W'(PARM_WIDTH);
      o_last <= 1'b0;
      o_done <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q  <= {adj_c[BCD_W-2:0], sh_q[PARM_WIDTH-1]};
      sh_q   <= {sh_q[PARM_WIDTH-2:0], 1'b0};
      cnt_q  <= cnt_q - CNT_W'(1);
      o_last <= (cnt_q == CNT_W'(2));
      o_done <= (cnt_q == CNT_W'(1));
    end else begin
      o_last <= 1'b0;
      o_done <= 1'b0;
    end
  end

endmodule

// File: rtl/acl_readings_ascii_formatter.sv
// Formats N packed sensor readings into one fixed-pitch ASCII line using a
// shared serial BCD engine; decimal or hex per conversion.
module acl_readings_ascii_formatter
  import acl_ascii_pkg::*;
#(
  parameter int unsigned                  PARM_CHANNELS    = 4,
  parameter int unsigned                  PARM_WIDTH       = 16,
  parameter int unsigned                  PARM_DIGITS      = 4,
  parameter int unsigned                  PARM_FRAC        = 3,
  parameter logic [PARM_CHANNELS*8-1:0]   PARM_LABELS      = "XYZT",
  parameter logic [PARM_CHANNELS-1:0]     PARM_SIGNED_MASK = 4'b0111,
  parameter logic [PARM_CHANNELS-1:0]     PARM_POINT_MASK  = 4'b0111,
  parameter bit                           PARM_LSB_FIRST   = 1'b1
) (
  input  logic                                               i_clk,
  input  logic                                               i_rst,
  input  logic [PARM_CHANNELS*PARM_WIDTH-1:0]                i_readings,
  input  logic                                               i_reading_inactive,
  input  logic                                               i_hex_mode,
  input  logic                                               i_valid,
  output logic                                               o_in_ready,
  output logic [PARM_CHANNELS*field_width(PARM_DIGITS)*8-1:0] o_line,
  output logic                                               o_valid,
  input  logic                                               i_ready
);

  localparam int unsigned C     = PARM_CHANNELS;
  localparam int unsigned W     = PARM_WIDTH;
  localparam int unsigned D     = PARM_DIGITS;
  localparam int unsigned FRAC  = PARM_FRAC;
  localparam int unsigned F     = field_width(PARM_DIGITS);
  localparam int unsigned FW    = F * 8;
  localparam int unsigned LW    = C * FW;
  localparam int unsigned NB    = W / 8;
  localparam int unsigned NH    = W / 4;
  localparam int unsigned BCD_W = bcd_width(PARM_WIDTH);
  localparam int unsigned NIB   = BCD_W / 4;
  localparam int unsigned CH_W  = (C > 1) ? $clog2(C) : 1;

  // Reject parameter sets the field layout cannot represent.
  if ((2 + NH) > F) begin : g_bad_hex_fit
    $error("hex field does not fit in the decimal field pitch");
  end
  if ((W % 8) != 0 || W < 8 || W > 32) begin : g_bad_width
    $error("reading width must be a multiple of 8 in 8..32");
  end
  if (FRAC >= D) begin : g_bad_frac
    $error("fraction digits must be fewer than total digits");
  end

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [W-1:0]      val_q [C];
  logic              inactive_q;
  logic              hex_q;

  logic [W-1:0]      in_val_c [C];
  logic [W-1:0]      cur_c;
  logic [W-1:0]      mag_c;
  logic [7:0]        lbl_c;
  logic              signed_c;
  logic              point_c;
  logic              neg_c;
  logic              ovf_c;
  logic [7:0]        fc [F];
  logic [FW-1:0]     field_c;
  logic [LW-1:0]     line_upd_c;
  logic              start_c;

  logic [BCD_W-1:0]  bcd;
  logic              bcd_last;
  logic              bcd_done;

  // Decimal digit character, or '*' when the value overflows the field.
  function automatic logic [7:0] dec_char(input logic [3:0] n, input logic star);
    return star ? ASCII_STAR : (ASCII_ZERO + {4'h0, n});
  endfunction

  // Split the input bus per channel, reversing byte order when bytes arrive LS first.
  always_comb begin
    for (int unsigned c = 0; c < C; c++) begin
      in_val_c[c] = i_readings[(C-1-c)*W +: W];
      if (PARM_LSB_FIRST) begin
        for (int unsigned b = 0; b < NB; b++) begin
          in_val_c[c][b*8 +: 8] = i_readings[(C-1-c)*W + (NB-1-b)*8 +: 8];
        end
      end
    end
  end

  // Per-channel attributes of the channel currently being converted.
  always_comb begin
    cur_c    = '0;
    lbl_c    = ASCII_SPACE;
    signed_c = 1'b0;
    point_c  = 1'b0;
    for (int unsigned c = 0; c < C; c++) begin
      if (ch_q == CH_W'(c)) begin
        cur_c    = val_q[c];
        lbl_c    = PARM_LABELS[(C-1-c)*8 +: 8];
        signed_c = PARM_SIGNED_MASK[c];
        point_c  = PARM_POINT_MASK[c];
      end
    end
    neg_c   = signed_c & cur_c[W-1];
    mag_c   = neg_c ? (W'(0) - cur_c) : cur_c;
    start_c = (state_q == ST_LOAD);
  end

  // Overflow when any BCD digit above the displayed ones is nonzero.
  always_comb begin
    ovf_c = 1'b0;
    for (int unsigned n = D; n < NIB; n++) begin
      if (bcd[4*n +: 4] != 4'd0) ovf_c = 1'b1;
    end
  end

  // Render the current channel's field and merge it into a copy of the line.
  always_comb begin
    for (int unsigned k = 0; k < F; k++) fc[k] = ASCII_SPACE;
    fc[0] = lbl_c;
    if (hex_q) begin
      fc[1] = ASCII_COLON;
      for (int unsigned i = 0; i < NH; i++) begin
        fc[2+i] = inactive_q ? ASCII_UNDER : ascii_of_hdigit(cur_c[4*(NH-1-i) +: 4]);
      end
    end else if (inactive_q) begin
      for (int unsigned k = 1; k < F - 1; k++) fc[k] = ASCII_UNDER;
    end else begin
      fc[1] = neg_c ? ASCII_MINUS : ASCII_SPACE;
      for (int unsigned d = 0; d < D; d++) begin
        if (point_c && d >= D - FRAC) fc[3+d] = dec_char(bcd[4*(D-1-d) +: 4], ovf_c);
        else fc[2+d] = dec_char(bcd[4*(D-1-d) +: 4], ovf_c);
      end
      if (point_c) fc[2+D-FRAC] = ASCII_POINT;
    end
    for (int unsigned k = 0; k < F; k++) field_c[(F-1-k)*8 +: 8] = fc[k];
    line_upd_c = o_line;
    for (int unsigned c = 0; c < C; c++) begin
      if (ch_q == CH_W'(c)) line_upd_c[(C-1-c)*FW +: FW] = field_c;
    end
  end

  bin_to_bcd_serial #(
    .PARM_WIDTH (W)
  ) u_bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start_c),
    .i_bin   (mag_c),
    .o_bcd   (bcd),
    .o_last  (bcd_last),
    .o_done  (bcd_done)
  );

  // Conversion sequencer: one LOAD/SHIFT/WRITE pass per channel, then hold the line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      inactive_q <= 1'b0;
      hex_q      <= 1'b0;
      o_line     <= {(C*F){ASCII_SPACE}};
      o_valid    <= 1'b0;
      o_in_ready <= 1'b1;
      for (int unsigned c = 0; c < C; c++) val_q[c] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && o_in_ready) begin
            for (int unsigned c = 0; c < C; c++) val_q[c] <= in_val_c[c];
            inactive_q <= i_reading_inactive;
            hex_q      <= i_hex_mode;
            ch_q       <= '0;
            o_in_ready <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (bcd_last) state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (bcd_done) o_line <= line_upd_c;
          if (ch_q == CH_W'(C - 1)) begin
            state_q <= ST_DONE;
          end else begin
            ch_q    <= ch_q + CH_W'(1);
            state_q <= ST_LOAD;
          end
        end
        ST_DONE: begin
          if (!o_valid) begin
            o_valid <= 1'b1;
          end else if (i_ready) begin
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acl_readings_ascii_formatter.sv
// Scoreboard bench for acl_readings_ascii_formatter with default parameters.
module tb_acl_readings_ascii_formatter;

  localparam int LW  = 256;
  localparam int LAT = 73;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   readings;
  logic          inactive;
  logic          hex_mode;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] line;
  logic          out_valid;
  logic          out_ready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [LW-1:0] line;
    int            acc;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [LW-1:0] SPACES = {32{8'h20}};
  localparam logic [LW-1:0] L_DEC  = "X-0.123 Y 0.345 Z 1.123 T 5201  ";
  localparam logic [LW-1:0] L_OVF1 = "X *.*** Y-*.*** Z-0.001 T ****  ";
  localparam logic [LW-1:0] L_OVF2 = "X-*.*** Y 9.999 Z *.*** T 9999  ";
  localparam logic [LW-1:0] L_HEX  = "X:0123  Y:ABCD  Z:00FF  T:1451  ";
  localparam logic [LW-1:0] L_HEXN = "X:FF85  Y:0000  Z:8000  T:FFFF  ";
  localparam logic [LW-1:0] L_INAD = "X______ Y______ Z______ T______ ";
  localparam logic [LW-1:0] L_INAH = "X:____  Y:____  Z:____  T:____  ";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  acl_readings_ascii_formatter dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_readings         (readings),
    .i_reading_inactive (inactive),
    .i_hex_mode         (hex_mode),
    .i_valid            (in_valid),
    .o_in_ready         (in_ready),
    .o_line             (line),
    .o_valid            (out_valid),
    .i_ready            (out_ready)
  );

  // Pack four readings LS byte first, channel 0 in the MSBs.
  function automatic logic [63:0] rd(input logic [15:0] x, input logic [15:0] y,
                                     input logic [15:0] z, input logic [15:0] t);
    return {x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8], t[7:0], t[15:8]};
  endfunction

  task automatic check_line(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Issue one request; optionally record the expected line and accept cycle.
  task automatic send(input logic [63:0] r, input logic inact, input logic hex,
                      input logic [LW-1:0] exp, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_int("in_ready_before_send", int'(in_ready), 1);
    readings = r;
    inactive = inact;
    hex_mode = hex;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (push) exp_q.push_back('{exp, cyc});
    readings = ~r;
    inactive = ~inact;
    hex_mode = ~hex;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_int("returns_idle", int'(in_ready), 1);
  endtask

  // Monitor: compare each newly presented line and its latency against the queue.
  initial begin : monitor
    logic was;
    exp_t e;
    was = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !was) begin
        if (exp_q.size() == 0) begin
          check_int("spurious_valid", int'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check_line("line", line, e.line);
          check_int("latency", cyc - e.acc, LAT);
        end
      end
      was = out_valid;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    rst       = 1'b1;
    readings  = '0;
    inactive  = 1'b0;
    hex_mode  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_line("reset_line", line, SPACES);
    check_int("reset_valid", int'(out_valid), 0);
    check_int("reset_in_ready", int'(in_ready), 1);

    send(rd(16'hFF85, 16'd345, 16'd1123, 16'd5201), 1'b0, 1'b0, L_DEC, 1'b1);
    wait_idle();
    send(rd(16'd12345, 16'h8000, 16'hFFFF, 16'd65535), 1'b0, 1'b0, L_OVF1, 1'b1);
    wait_idle();
    send(rd(16'h8000, 16'd9999, 16'd10000, 16'd9999), 1'b0, 1'b0, L_OVF2, 1'b1);
    wait_idle();
    send(rd(16'h0123, 16'hABCD, 16'h00FF, 16'h1451), 1'b0, 1'b1, L_HEX, 1'b1);
    wait_idle();
    send(rd(16'hFF85, 16'h0000, 16'h8000, 16'hFFFF), 1'b0, 1'b1, L_HEXN, 1'b1);
    wait_idle();
    send(rd(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), 1'b1, 1'b0, L_INAD, 1'b1);
    wait_idle();
    send(rd(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), 1'b1, 1'b1, L_INAH, 1'b1);
    wait_idle();

    // Downstream stall: line and valid held, new requests ignored.
    out_ready = 1'b0;
    send(rd(16'hFF85, 16'd345, 16'd1123, 16'd5201), 1'b0, 1'b0, L_DEC, 1'b1);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_int("stall_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      readings = rd(16'd1, 16'd2, 16'd3, 16'd4);
      hex_mode = 1'b1;
      @(negedge clk);
      check_line("stall_line", line, L_DEC);
      check_int("stall_valid", int'(out_valid), 1);
      check_int("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_int("release_valid", int'(out_valid), 0);
    check_int("release_in_ready", int'(in_ready), 1);
    repeat (90) @(negedge clk);

    // Reset partway through a conversion.
    send(rd(16'd12345, 16'd1, 16'd2, 16'd3), 1'b0, 1'b0, SPACES, 1'b0);
    repeat (29) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_line("midreset_line", line, SPACES);
    check_int("midreset_valid", int'(out_valid), 0);
    check_int("midreset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    send(rd(16'h0123, 16'hABCD, 16'h00FF, 16'h1451), 1'b0, 1'b1, L_HEX, 1'b1);
    wait_idle();

    repeat (5) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
